iq_correlator: RTL and testbench
================================

# iq_correlator

Quadrature correlator at the receive end of the NCO sample stream. Multiplies each incoming signed 5-bit sample by the sine and cosine samples of a local NCO. Integrates the I and Q products over 2^LOG2_LEN accepted samples (integrate-and-dump). Presents each dump as signed I/Q sums plus a magnitude estimate on a valid/ready output port, for tone detection and phase tracking downstream.

## Interface
- LOG2_LEN, 6: log2 of samples per dump; legal 1..10.
- ACC_W, 10+LOG2_LEN: width of accumulators and outputs (derived; not overridden).
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  pipeline advance enable; stages 1–3 move only when high.
- run  in  1  high = correlate; low = sample counter, accumulators, pipeline valids and overrun cleared synchronously (gated by clk_en).
- sample_in  in  5  signed two's-complement input sample.
- sample_valid  in  1  sample_in valid this enabled cycle.
- lo_sine  in  5  signed NCO sine sample, time-aligned with sample_in by the integrator.
- lo_cosine  in  5  signed NCO cosine sample, aligned likewise.
- i_sum  out  ACC_W  signed Σ sample·cos for the last dump.
- q_sum  out  ACC_W  signed Σ sample·sin for the last dump.
- magnitude  out  ACC_W  unsigned max(|I|,|Q|) + (min(|I|,|Q|)>>1).
- result_valid  out  1  result registers hold an unconsumed dump.
- result_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: a dump was overwritten before being accepted.

## Operation
- Reset: i_sum, q_sum, magnitude, result_valid, overrun all 0. The sample counter, both accumulators and all stage valids are also 0.
- Stage 1 (enabled edge, run=1, sample_valid=1):
  - Register p_i = sample_in·lo_cosine and p_q = sample_in·lo_sine as 10-bit signed products. Full range −240..+256 is exact.
  - Tag the sample last when sample counter = 2^LOG2_LEN−1.
  - Increment the counter, wrapping to 0.
- Stage 1, sample_valid=0: stage-1 valid goes 0. The counter is unchanged.
- Stage 2 (enabled edge, stage-1 valid):
  - Not last: acc_i += p_i and acc_q += p_q, with products sign-extended to ACC_W.
  - Last: capture acc+p into stage-3 registers, set stage-3 valid, clear acc_i/acc_q to 0 in the same edge.
- Stage 3 (enabled edge, stage-3 valid): compute abs values and the magnitude, load i_sum/q_sum/magnitude, set result_valid.
  - abs of the most-negative value is not reachable given the 10-bit product range and 2^LOG2_LEN terms.
- No saturation. Sums are exact because ACC_W covers 2^LOG2_LEN · 256.
- Output port states:
  - IDLE: result_valid=0.
  - FULL: result_valid=1.
  - IDLE→FULL on stage-3 load.
  - FULL→IDLE on any clock edge with result_ready=1 and no load. This is not gated by clk_en.
  - FULL with load and result_ready=1: the new result is loaded, result_valid stays 1, and overrun is unchanged.
  - FULL with load and result_ready=0: the new result overwrites, result_valid stays 1, and overrun is set.
- overrun clears only on reset or run=0 (enabled edge). It is not cleared by a handshake.
- run 1→0 mid-dump: the partial accumulation is discarded and the counter returns to 0. Results already in the output registers and result_valid are kept.
- run 0→1: the first accepted sample is sample 0 of a new dump.
- reset_n low mid-operation: all state clears immediately, asynchronously.

## Timing
- Latency: the last sample is accepted at enabled edge t. Its products register at t. The accumulator dumps at enabled edge t+1. result_valid rises at enabled edge t+2.
- With clk_en permanently high, that is 2 clocks after the accepting edge.
- Throughput: one sample per enabled cycle. Dumps can be back-to-back; the minimum dump spacing is 2^LOG2_LEN enabled cycles.
- The consumer must accept within 2^LOG2_LEN enabled cycles of result_valid rising, or overrun sets.
- The outputs are registers; none is combinational from an input.
- result_ready→result_valid deassertion takes effect at the same edge.

## Test plan
- Reset with LOG2_LEN=6: all outputs 0; counter at 0 after release.
- Constant sample_in=15, lo_cosine=15, lo_sine=0, sample_valid=1 for 64 cycles:
  - i_sum=14400, q_sum=0, magnitude=14400.
  - result_valid rises 2 clocks after the 64th sample.
- Extreme values: sample_in=−16, lo_cosine=−16, lo_sine=15 for 64 samples:
  - i_sum=16384, q_sum=−15360, magnitude=16384+7680=24064.
  - No wrap in either sum.
- Gaps: sample_valid toggling and clk_en at 50% duty, 64 valid samples of the test-2 stimulus.
  - Same 14400 result.
  - No dump before the 64th accepted sample.
- Overrun: result_ready=0 through two consecutive dumps.
  - The second dump overwrites, overrun=1, result_valid=1.
  - Then result_ready=1: result_valid→0 and overrun stays 1 until run=0.
- run dropped after 30 samples, then restored, then 64 test-2 samples: i_sum=14400 exactly, proving the partial dump was discarded.
- Asynchronous reset asserted mid-dump: outputs go to 0 without a clock edge.

Source files
------------

// File: rtl/iq_correlator.sv
// Quadrature integrate-and-dump correlator: mixes a 5-bit sample stream with NCO
// sine/cosine, sums 2^LOG2_LEN products and hands each dump out on a valid/ready port.
module iq_correlator #(
    parameter  int LOG2_LEN = 6,
    localparam int ACC_W    = 10 + LOG2_LEN
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clk_en,
    input  logic                    run,
    input  logic signed [4:0]       sample_in,
    input  logic                    sample_valid,
    input  logic signed [4:0]       lo_sine,
    input  logic signed [4:0]       lo_cosine,
    output logic signed [ACC_W-1:0] i_sum,
    output logic signed [ACC_W-1:0] q_sum,
    output logic        [ACC_W-1:0] magnitude,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    overrun
);

    logic        [LOG2_LEN-1:0] sample_cnt;
    logic                       s1_valid;
    logic                       s1_last;
    logic signed [9:0]          p_i;
    logic signed [9:0]          p_q;
    logic signed [ACC_W-1:0]    acc_i;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       s3_valid;
    logic signed [ACC_W-1:0]    s3_i;
    logic signed [ACC_W-1:0]    s3_q;
    logic        [ACC_W-1:0]    abs_i;
    logic        [ACC_W-1:0]    abs_q;
    logic        [ACC_W-1:0]    mag_next;
    logic                       load;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        abs_i    = s3_i[ACC_W-1] ? -s3_i : s3_i;
        abs_q    = s3_q[ACC_W-1] ? -s3_q : s3_q;
        mag_next = (abs_i > abs_q) ? abs_i + (abs_q >> 1) : abs_q + (abs_i >> 1);
        load     = clk_en && run && s3_valid;
    end

    // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            p_i        <= '0;
            p_q        <= '0;
        end else if (clk_en) begin
            if (!run) begin
                sample_cnt <= '0;
                s1_valid   <= 1'b0;
            end else if (sample_valid) begin
                // Size casts keep signedness, so the 10-bit product is exact.
                p_i        <= 10'(sample_in) * 10'(lo_cosine);
                p_q        <= 10'(sample_in) * 10'(lo_sine);
                s1_last    <= &sample_cnt;
                sample_cnt <= sample_cnt + 1'b1;
                s1_valid   <= 1'b1;
            end else begin
                s1_valid   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_i    <= '0;
            acc_q    <= '0;
            s3_valid <= 1'b0;
            s3_i     <= '0;
            s3_q     <= '0;
        end else if (clk_en) begin
            s3_valid <= 1'b0;
            if (!run) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (s1_valid) begin
                if (s1_last) begin
                    s3_i     <= acc_i + ACC_W'(p_i);
                    s3_q     <= acc_q + ACC_W'(p_q);
                    s3_valid <= 1'b1;
                    acc_i    <= '0;
                    acc_q    <= '0;
                end else begin
                    acc_i <= acc_i + ACC_W'(p_i);
                    acc_q <= acc_q + ACC_W'(p_q);
                end
            end
        end
    end

    // The consumer handshake runs every clock; only loads and run-clears follow clk_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_sum        <= '0;
            q_sum        <= '0;
            magnitude    <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load) begin
                i_sum        <= s3_i;
                q_sum        <= s3_q;
                magnitude    <= mag_next;
                result_valid <= 1'b1;
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end

            if (clk_en && !run)
                overrun <= 1'b0;
            else if (load && result_valid && !result_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iq_correlator.sv
// Directed/randomized bench for iq_correlator: an arithmetic model sums accepted
// sample products per dump and the outputs are checked with immediate assertions.
module tb_iq_correlator;

    localparam int L = 6;
    localparam int W = 10 + L;
    localparam int N = 1 << L;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                clk_en;
    logic                run;
    logic signed [4:0]   sample_in;
    logic                sample_valid;
    logic signed [4:0]   lo_sine;
    logic signed [4:0]   lo_cosine;
    logic signed [W-1:0] i_sum;
    logic signed [W-1:0] q_sum;
    logic        [W-1:0] magnitude;
    logic                result_valid;
    logic                result_ready;
    logic                overrun;

    int vectors     = 0;
    int miscompares = 0;
    int model_n, model_i, model_q;
    int exp_i, exp_q, exp_m;
    int saved_i;
    int accepted, guard;
    logic early;

    iq_correlator #(.LOG2_LEN(L)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clk_en       (clk_en),
        .run          (run),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .lo_sine      (lo_sine),
        .lo_cosine    (lo_cosine),
        .i_sum        (i_sum),
        .q_sum        (q_sum),
        .magnitude    (magnitude),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    function automatic int mag_of(input int i, input int q);
        int ai, aq;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        return (ai > aq) ? ai + aq / 2 : aq + ai / 2;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        model_n = 0;
        model_i = 0;
        model_q = 0;
    endtask

    // One clock of stimulus; the model only counts samples the DUT is meant to accept.
    task automatic drive(input int s, input int c, input int si, input logic en, input logic v);
        sample_in    = 5'(s);
        lo_cosine    = 5'(c);
        lo_sine      = 5'(si);
        clk_en       = en;
        sample_valid = v;
        step();
        if (en && v && run) begin
            model_i += s * c;
            model_q += s * si;
            model_n++;
            if (model_n == N) begin
                exp_i = model_i;
                exp_q = model_q;
                exp_m = mag_of(model_i, model_q);
                model_clear();
            end
        end
    endtask

    task automatic drive_const(input int n, input int s, input int c, input int si);
        for (int k = 0; k < n; k++) drive(s, c, si, 1'b1, 1'b1);
    endtask

    task automatic drive_random(input int n);
        for (int k = 0; k < n; k++)
            drive(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                  int'($urandom_range(0, 31)) - 16, 1'b1, 1'b1);
    endtask

    task automatic finish_dump();
        sample_valid = 1'b0;
        clk_en       = 1'b1;
        step();
        step();
    endtask

    task automatic run_low();
        run          = 1'b0;
        clk_en       = 1'b1;
        sample_valid = 1'b0;
        step();
        model_clear();
        run = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_i"},   i_sum,        exp_i);
        check({tag, "_q"},   q_sum,        exp_q);
        check({tag, "_mag"}, magnitude,    exp_m);
        check({tag, "_rv"},  result_valid, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i"},   i_sum,        0);
        check({tag, "_q"},   q_sum,        0);
        check({tag, "_mag"}, magnitude,    0);
        check({tag, "_rv"},  result_valid, 0);
        check({tag, "_ovr"}, overrun,      0);
    endtask

    initial begin
        reset_n      = 1'b0;
        clk_en       = 1'b0;
        run          = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        lo_sine      = '0;
        lo_cosine    = '0;
        result_ready = 1'b0;
        model_clear();
        #12;
        check_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        run     = 1'b1;

        // Constant tone on I only, with latency checked edge by edge.
        drive_const(N, 15, 15, 0);
        check("t2_rv_at_last", result_valid, 0);
        sample_valid = 1'b0;
        step();
        check("t2_rv_plus1", result_valid, 0);
        step();
        check("t2_rv_plus2", result_valid, 1);
        check("t2_i",   i_sum,     14400);
        check("t2_q",   q_sum,     0);
        check("t2_mag", magnitude, 14400);
        result_ready = 1'b1;
        step();
        check("t2_consumed", result_valid, 0);

        // Extreme operands: largest positive and negative products.
        drive_const(N, -16, -16, 15);
        finish_dump();
        check("t3_i",   i_sum,     16384);
        check("t3_q",   q_sum,     -15360);
        check("t3_mag", magnitude, 24064);
        step();
        check("t3_consumed", result_valid, 0);

        // Random clk_en and sample_valid gaps until 64 samples are accepted.
        accepted = 0;
        guard    = 0;
        early    = 1'b0;
        while (accepted < N && guard < 2000) begin
            logic en, v;
            en = 1'($urandom_range(0, 1));
            v  = 1'($urandom_range(0, 1));
            drive(15, 15, 0, en, v);
            if (en && v) accepted++;
            if (accepted < N && result_valid) early = 1'b1;
            guard++;
        end
        check("gap_accepted", accepted, N);
        check("gap_no_early_dump", early, 0);
        finish_dump();
        check("gap_i",   i_sum,     14400);
        check("gap_mag", magnitude, 14400);
        check("gap_rv",  result_valid, 1);
        step();

        drive_random(N);
        finish_dump();
        check_model("rand1");
        step();

        // Two dumps without a handshake: the second overwrites and flags overrun.
        result_ready = 1'b0;
        drive_random(N);
        finish_dump();
        check_model("ovr_a");
        check("ovr_a_flag", overrun, 0);
        drive_random(N);
        finish_dump();
        check_model("ovr_b");
        check("ovr_b_flag", overrun, 1);
        saved_i = exp_i;
        result_ready = 1'b1;
        step();
        check("ovr_handshake_rv",  result_valid, 0);
        check("ovr_sticky",        overrun,      1);
        result_ready = 1'b0;
        run_low();
        check("ovr_cleared_by_run", overrun, 0);
        check("run_low_keeps_i",    i_sum,   saved_i);

        // Partial dump discarded when run drops.
        drive_const(30, 15, 15, 0);
        run_low();
        drive_const(N, 15, 15, 0);
        finish_dump();
        check("rundrop_i", i_sum, 14400);
        check_model("rundrop");

        // Asynchronous reset mid-dump, away from any clock edge.
        drive_random(20);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_clear();
        @(negedge clock);
        reset_n      = 1'b1;
        result_ready = 1'b1;
        drive_random(N);
        finish_dump();
        check_model("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
